// File: rtl/board_renderer_pkg.sv
// Shared board geometry and render types for the front-buffer reader.
package board_renderer_pkg;
   localparam int WORD_SIZE      = 16;
   localparam int LOG_WORD_SIZE  = 4;
   localparam int BOARD_SIZE     = 32;
   localparam int LOG_BOARD_SIZE = 5;
   localparam int WORDS_PER_ROW  = BOARD_SIZE / WORD_SIZE;
   localparam int LOG_MAX_ADDR   = 6;

   typedef logic [LOG_BOARD_SIZE-1:0] pos_t;
   typedef logic [11:0]               rgb_t;

   typedef struct packed {
      logic                     in_board;
      logic [LOG_WORD_SIZE-1:0] bit_idx;
      logic                     grid;
      logic                     cursor_hit;
   } render_side_t;
endpackage

// File: rtl/board_renderer_delay.sv
// Fixed-depth shift register with a settable reset value; carries sync and side info.
module render_delay #(
   parameter int             W       = 1,
   parameter int             DEPTH   = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [DEPTH-1:0][W-1:0] r_pipe;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pipe <= {DEPTH{RST_VAL}};
      end else begin
         r_pipe[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/board_renderer.sv
// Raster reader of the board front buffer: cell words -> RGB444 pixels with cursor,
// optional grid and a once-per-frame swap trigger after the last board line.
module board_renderer
   import board_renderer_pkg::*;
#(
   parameter int          LOG_CELL_PX  = 2,
   parameter logic [10:0] BOARD_X0     = 11'd64,
   parameter logic [9:0]  BOARD_Y0     = 10'd32,
   parameter bit          GRID_EN      = 1'b1,
   parameter rgb_t        ALIVE_COLOR  = 12'hFFF,
   parameter rgb_t        DEAD_COLOR   = 12'h000,
   parameter rgb_t        GRID_COLOR   = 12'h222,
   parameter rgb_t        CURSOR_COLOR = 12'hF00
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [10:0]             hcount_in,
   input  logic [9:0]              vcount_in,
   input  logic                    hsync_in,
   input  logic                    vsync_in,
   input  logic                    blank_in,
   input  pos_t                    cursor_x_in,
   input  pos_t                    cursor_y_in,
   input  logic [WORD_SIZE-1:0]    data_r_in,
   output logic [LOG_MAX_ADDR-1:0] addr_r_out,
   output rgb_t                    pixel_out,
   output logic                    hsync_out,
   output logic                    vsync_out,
   output logic                    blank_out,
   output logic                    frame_start_out
);
   localparam logic [10:0] BOARD_PX_X  = 11'(BOARD_SIZE << LOG_CELL_PX);
   localparam logic [9:0]  BOARD_PX_Y  = 10'(BOARD_SIZE << LOG_CELL_PX);
   localparam logic [9:0]  FRAME_END_V = BOARD_Y0 + BOARD_PX_Y;

   logic [10:0]             w_dx;
   logic [9:0]              w_dy;
   pos_t                    w_cx, w_cy;
   logic                    w_in_board;
   render_side_t            w_side, w_side_d;
   logic [LOG_MAX_ADDR-1:0] w_addr;
   logic [2:0]              w_sync_d;

   logic [LOG_MAX_ADDR-1:0] r_addr;
   rgb_t                    r_pixel;
   logic                    r_hsync, r_vsync, r_blank;
   logic                    r_armed, r_frame_start;

   // S0: cell mapping, address and side info
   assign w_dx = hcount_in - BOARD_X0;
   assign w_dy = vcount_in - BOARD_Y0;
   assign w_cx = pos_t'(w_dx >> LOG_CELL_PX);
   assign w_cy = pos_t'(w_dy >> LOG_CELL_PX);
   assign w_in_board = (hcount_in >= BOARD_X0) && (hcount_in < BOARD_X0 + BOARD_PX_X) &&
                       (vcount_in >= BOARD_Y0) && (vcount_in < BOARD_Y0 + BOARD_PX_Y);

   assign w_addr = LOG_MAX_ADDR'(w_cy) * LOG_MAX_ADDR'(WORDS_PER_ROW) +
                   LOG_MAX_ADDR'(w_cx[LOG_BOARD_SIZE-1:LOG_WORD_SIZE]);

   always_comb begin
      w_side            = '0;
      w_side.in_board   = w_in_board;
      // leftmost cell of a word sits in the MSB
      w_side.bit_idx    = LOG_WORD_SIZE'(WORD_SIZE-1) - w_cx[LOG_WORD_SIZE-1:0];
      w_side.grid       = GRID_EN && ((w_dx[LOG_CELL_PX-1:0] == '0) ||
                                      (w_dy[LOG_CELL_PX-1:0] == '0));
      w_side.cursor_hit = w_in_board && (w_cx == cursor_x_in) && (w_cy == cursor_y_in);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in)          r_addr <= '0;
      else if (w_in_board) r_addr <= w_addr;
   end

   // S0+S1 for side info and syncs; S2 is the output register below
   render_delay #(.W($bits(render_side_t)), .DEPTH(2), .RST_VAL('0)) u_side_dly (
      .i_clk (clk_in),
      .i_rst (rst_in),
      .i_d   (w_side),
      .o_q   (w_side_d)
   );

   render_delay #(.W(3), .DEPTH(2), .RST_VAL(3'b111)) u_sync_dly (
      .i_clk (clk_in),
      .i_rst (rst_in),
      .i_d   ({hsync_in, vsync_in, blank_in}),
      .o_q   (w_sync_d)
   );

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_pixel <= DEAD_COLOR;
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
         r_blank <= 1'b1;
      end else begin
         {r_hsync, r_vsync, r_blank} <= w_sync_d;
         if (!w_side_d.in_board || w_sync_d[0]) r_pixel <= DEAD_COLOR;
         else if (w_side_d.cursor_hit)          r_pixel <= CURSOR_COLOR;
         else if (w_side_d.grid)                r_pixel <= GRID_COLOR;
         else if (data_r_in[w_side_d.bit_idx])  r_pixel <= ALIVE_COLOR;
         else                                   r_pixel <= DEAD_COLOR;
      end
   end

   // Armed only by a real top-of-frame, so a mid-frame reset never fires a partial trigger
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_armed       <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;
         if (vcount_in == '0) r_armed <= 1'b1;
         if (r_armed && hcount_in == '0 && vcount_in == FRAME_END_V) begin
            r_frame_start <= 1'b1;
            r_armed       <= 1'b0;
         end
      end
   end

   assign addr_r_out      = r_addr;
   assign pixel_out       = r_pixel;
   assign hsync_out       = r_hsync;
   assign vsync_out       = r_vsync;
   assign blank_out       = r_blank;
   assign frame_start_out = r_frame_start;
endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: one grid-enabled and one grid-disabled instance on shared timing.
module tb_board_renderer;
   import board_renderer_pkg::*;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   logic [10:0] hcount = '0;
   logic [9:0]  vcount = 10'd1;
   logic hs = 1'b1, vs = 1'b1, bl = 1'b0;
   pos_t cur_x = '0, cur_y = 5'd20;

   logic [WORD_SIZE-1:0] mem [0:(1<<LOG_MAX_ADDR)-1];
   logic [WORD_SIZE-1:0] data_a, data_b;
   logic [LOG_MAX_ADDR-1:0] addr_a, addr_b;
   rgb_t pix_a, pix_b;
   logic hs_a, vs_a, bl_a, fs_a, hs_b, vs_b, bl_b, fs_b;

   int n_err = 0;
   int n_chk = 0;

   typedef struct {
      int   h, v;
      bit   c, hs, vs, bl;
      rgb_t a, b;
   } exp_t;
   exp_t hist[$];

   always #5 clk_in = ~clk_in;

   // front buffer: address register inside the DUT plus one memory register here
   always_ff @(posedge clk_in) begin
      data_a <= mem[addr_a];
      data_b <= mem[addr_b];
   end

   board_renderer #(.GRID_EN(1'b1)) dut_a (
      .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount), .vcount_in(vcount),
      .hsync_in(hs), .vsync_in(vs), .blank_in(bl), .cursor_x_in(cur_x), .cursor_y_in(cur_y),
      .data_r_in(data_a), .addr_r_out(addr_a), .pixel_out(pix_a), .hsync_out(hs_a),
      .vsync_out(vs_a), .blank_out(bl_a), .frame_start_out(fs_a));

   board_renderer #(.GRID_EN(1'b0)) dut_b (
      .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount), .vcount_in(vcount),
      .hsync_in(hs), .vsync_in(vs), .blank_in(bl), .cursor_x_in(cur_x), .cursor_y_in(cur_y),
      .data_r_in(data_b), .addr_r_out(addr_b), .pixel_out(pix_b), .hsync_out(hs_b),
      .vsync_out(vs_b), .blank_out(bl_b), .frame_start_out(fs_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one pixel; outputs after the edge belong to the pixel driven two calls earlier.
   task automatic cyc(input int h, input int v, input bit b, input bit hsi, input bit vsi,
                      input bit c, input rgb_t ea, input rgb_t eb);
      exp_t e;
      hcount = 11'(h);
      vcount = 10'(v);
      bl = b;
      hs = hsi;
      vs = vsi;
      e.h = h; e.v = v; e.c = c; e.hs = hsi; e.vs = vsi; e.bl = b; e.a = ea; e.b = eb;
      hist.push_back(e);
      @(posedge clk_in);
      #1;
      if (hist.size() == 3) begin
         e = hist.pop_front();
         if (e.c) begin
            chk($sformatf("pix_a h=%0d v=%0d", e.h, e.v), 32'(pix_a), 32'(e.a));
            chk($sformatf("pix_b h=%0d v=%0d", e.h, e.v), 32'(pix_b), 32'(e.b));
            chk($sformatf("syncs_a h=%0d v=%0d", e.h, e.v), {hs_a, vs_a, bl_a}, {e.hs, e.vs, e.bl});
            chk($sformatf("syncs_b h=%0d v=%0d", e.h, e.v), {hs_b, vs_b, bl_b}, {e.hs, e.vs, e.bl});
         end
      end
   endtask

   task automatic pix(input int h, input int v, input bit b, input rgb_t ea, input rgb_t eb);
      cyc(h, v, b, 1'b1, 1'b1, 1'b1, ea, eb);
   endtask

   task automatic idle(input int h, input int v);
      cyc(h, v, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000);
   endtask

   rgb_t e2a [9] = '{12'h000, 12'h222, 12'hFFF, 12'hFFF, 12'hFFF, 12'h222, 12'h000, 12'h000, 12'h000};
   rgb_t e2b [9] = '{12'h000, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000};
   rgb_t e4a [16] = '{12'h222, 12'h000, 12'h000, 12'h000, 12'h222, 12'h000, 12'h000, 12'h000,
                      12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'h000, 12'h000, 12'h000, 12'h000};
   rgb_t e4b [16] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
                      12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'h000, 12'h000, 12'h000, 12'h000};
   int   lines3 [6] = '{31, 32, 33, 100, 159, 160};

   initial begin
      int cnt_a, cnt_b, fs_h, fs_v;
      for (int i = 0; i < (1<<LOG_MAX_ADDR); i++) mem[i] = '0;

      // 1: reset asserted mid-line overrides everything, no early frame trigger
      repeat (2) idle(0, 1);
      rst_in = 1'b0;
      for (int h = 64; h < 71; h++) idle(h, 33);
      rst_in = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc(100 + i, 50, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000);
         chk("rst_pix_a", 32'(pix_a), 32'h000);
         chk("rst_pix_b", 32'(pix_b), 32'h000);
         chk("rst_syncs", {hs_a, vs_a, bl_a}, 3'b111);
         chk("rst_fs", {fs_a, fs_b}, 2'b00);
         chk("rst_addr", 32'(addr_a), 32'd0);
      end
      rst_in = 1'b0;
      idle(0, 160);
      chk("fs_after_rst", {fs_a, fs_b}, 2'b00);
      idle(1, 160);

      // 2: single live cell (0,0), bit mapping and addressing
      mem[0] = 16'h8000;
      for (int h = 63; h < 72; h++) begin
         pix(h, 33, 1'b0, e2a[h-63], e2b[h-63]);
         if (h >= 64) chk($sformatf("addr2 h=%0d", h), {26'd0, addr_a}, 32'd0);
      end
      for (int h = 64; h < 68; h++) pix(h, 32, 1'b0, 12'h222, 12'hFFF);
      pix(128, 33, 1'b0, 12'h222, 12'h000);
      chk("addr_word1", 32'(addr_a), 32'd1);
      pix(191, 33, 1'b0, 12'h000, 12'h000);
      chk("addr_lastcol", 32'(addr_b), 32'd1);
      repeat (3) idle(0, 1);

      // 3: all-ones board over selected lines incl. edges, with sync and blank patterns
      for (int i = 0; i < (1<<LOG_MAX_ADDR); i++) mem[i] = '1;
      foreach (lines3[k]) begin
         for (int h = 60; h < 196; h++) begin
            int v;
            bit b, inb;
            rgb_t ea, eb;
            v   = lines3[k];
            b   = (h >= 186);
            inb = (h >= 64) && (h < 192) && (v >= 32) && (v < 160);
            eb  = (inb && !b) ? 12'hFFF : 12'h000;
            ea  = (!inb || b) ? 12'h000 :
                  (((h - 64) % 4 == 0) || ((v - 32) % 4 == 0)) ? 12'h222 : 12'hFFF;
            cyc(h, v, b, !(h >= 180 && h < 184), (v != 160), 1'b1, ea, eb);
         end
      end
      repeat (3) idle(0, 1);

      // 6: blank inside the board wins over live cells
      pix(70, 41, 1'b0, 12'hFFF, 12'hFFF);
      pix(70, 41, 1'b1, 12'h000, 12'h000);
      pix(64, 41, 1'b1, 12'h000, 12'h000);
      pix(66, 41, 1'b0, 12'hFFF, 12'hFFF);
      repeat (3) idle(0, 1);

      // 4: cursor on the bottom-right cell of an empty board
      for (int i = 0; i < (1<<LOG_MAX_ADDR); i++) mem[i] = '0;
      cur_x = 5'd31;
      cur_y = 5'd31;
      pix(64, 157, 1'b0, 12'h222, 12'h000);
      chk("addr_row31_w0", 32'(addr_a), 32'd62);
      for (int h = 180; h < 196; h++) begin
         pix(h, 157, 1'b0, e4a[h-180], e4b[h-180]);
         if (h == 188) chk("addr_max", 32'(addr_a), 32'd63);
      end
      chk("addr_hold", 32'(addr_a), 32'd63);
      pix(187, 156, 1'b0, 12'h222, 12'h000);
      pix(188, 156, 1'b0, 12'hF00, 12'hF00);
      pix(190, 160, 1'b0, 12'h000, 12'h000);
      repeat (3) idle(0, 1);
      cur_x = '0;
      cur_y = 5'd20;

      // 5: two frames, exactly one trigger each, right after (0,160) is sampled
      for (int f = 0; f < 2; f++) begin
         cnt_a = 0; cnt_b = 0; fs_h = -1; fs_v = -1;
         for (int h = 0; h < 10; h++) begin
            idle(h, 0);
            cnt_a += int'(fs_a);
            cnt_b += int'(fs_b);
         end
         for (int v = 158; v < 162; v++) begin
            for (int h = 0; h < 200; h++) begin
               idle(h, v);
               if (fs_a) begin
                  fs_h = h;
                  fs_v = v;
               end
               cnt_a += int'(fs_a);
               cnt_b += int'(fs_b);
            end
         end
         chk($sformatf("fs_count_a f%0d", f), 32'(cnt_a), 32'd1);
         chk($sformatf("fs_count_b f%0d", f), 32'(cnt_b), 32'd1);
         chk($sformatf("fs_h f%0d", f), 32'(fs_h), 32'd0);
         chk($sformatf("fs_v f%0d", f), 32'(fs_v), 32'd160);
      end
      idle(0, 160);
      chk("fs_unarmed", {fs_a, fs_b}, 2'b00);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
